// File: rtl/siso_shift_ctrl.sv
// Transfer controller for an external DEPTH-stage SISO flip-flop chain: serializes a word MSB-first,
// flushes the chain and deserializes the returning bits. Optional loopback check: SISO_CHK_EN.
module siso_shift_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             shift_en,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] CNT_FIRST = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             shift_en_q, shift_en_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SISO_CHK_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
`ifdef SISO_CHK_EN
        shadow_d = shadow_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tx_d    = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SISO_CHK_EN
                    shadow_d = in_data;
                    err_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // Zero fill drives the flush bits once the word is exhausted.
                tx_d  = tx_q << 1;
                cnt_d = cnt_q + CW'(1);
                // A bit driven at cnt=k reaches ser_in DEPTH shifts later.
                if (cnt_q >= CNT_FIRST) begin
                    rx_d = (rx_q << 1) | WIDTH'(ser_in);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef SISO_CHK_EN
                    err_d = (rx_d != shadow_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == IDLE);
        shift_en_d  = (state_d == SHIFT);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            shift_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SISO_CHK_EN
            shadow_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            shift_en_q  <= shift_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SISO_CHK_EN
            shadow_q    <= shadow_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign shift_en  = shift_en_q;
    assign ser_out   = tx_q[WIDTH-1];
    assign out_valid = out_valid_q;
    assign out_data  = rx_q;
    assign busy      = busy_q;
`ifdef SISO_CHK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl driving a modelled 4-stage D flip-flop chain.
module tb_siso_shift_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             shift_en;
    logic             ser_out;
    logic             ser_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             err;

    logic [DEPTH-1:0] chain;
    logic             inv_en;

    int n_vec;
    int n_err;
    int cyc;

    siso_shift_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .shift_en (shift_en),
        .ser_out  (ser_out),
        .ser_in   (ser_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (shift_en) chain <= {chain[DEPTH-2:0], ser_out};
    end
    assign ser_in = chain[DEPTH-1] ^ inv_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Accept one word, then wait (bounded) for out_valid while recording the serial stream.
    task automatic run_word(input logic [WIDTH-1:0] d, output int nshift, output logic [11:0] pat);
        int n;
        nshift   = 0;
        pat      = '0;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (shift_en) begin
                pat = {pat[10:0], ser_out};
                nshift++;
            end
            tick();
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int              nsh;
    logic [11:0]     pat;
    int              seen_valid;
    int              acc_t[2];
    int              n_acc;
    logic [WIDTH-1:0] got_w[2];
    int              n_out;
    logic            exp_err;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        inv_en = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
`ifdef SISO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset with in_valid asserted
        tick(); tick();
        check_val("rst_in_ready",  32'(in_ready),  32'd1);
        check_val("rst_shift_en",  32'(shift_en),  32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy",      32'(busy),      32'd0);
        check_val("rst_err",       32'(err),       32'd0);
        check_val("rst_out_data",  32'(out_data),  32'h0);
        check_val("rst_ser_out",   32'(ser_out),   32'd0);
        in_valid = 1'b0; rst = 1'b0;
        tick();
        check_val("rst_no_accept", 32'(busy), 32'd0);

        // Single transfer A5
        run_word(8'hA5, nsh, pat);
        check_val("a5_shift_cycles", 32'(nsh),       32'd12);
        check_val("a5_ser_pattern",  32'(pat),       32'hA50);
        check_val("a5_out_valid",    32'(out_valid), 32'd1);
        check_val("a5_out_data",     32'(out_data),  32'hA5);
        check_val("a5_busy_done",    32'(busy),      32'd1);
        check_val("a5_err",          32'(err),       32'd0);
        release_out();
        check_val("a5_idle_valid", 32'(out_valid), 32'd0);
        check_val("a5_idle_ready", 32'(in_ready),  32'd1);
        check_val("a5_idle_busy",  32'(busy),      32'd0);

        // Backpressure with 3C
        run_word(8'h3C, nsh, pat);
        check_val("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_data", 32'(out_data),  32'h3C);
            check_val("bp_in_ready", 32'(in_ready),  32'd0);
            check_val("bp_shift_en", 32'(shift_en),  32'd0);
            check_val("bp_hold",     32'(out_valid), 32'd1);
            tick();
        end
        release_out();
        check_val("bp_idle_valid", 32'(out_valid), 32'd0);
        check_val("bp_idle_busy",  32'(busy),      32'd0);

        // Reset in the middle of shifting FF
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_val("mid_shifting", 32'(shift_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_shift_en", 32'(shift_en), 32'd0);
        check_val("mid_busy",     32'(busy),     32'd0);
        check_val("mid_in_ready", 32'(in_ready), 32'd1);
        check_val("mid_out_data", 32'(out_data), 32'h0);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        check_val("mid_no_valid", 32'(seen_valid), 32'd0);
        run_word(8'h81, nsh, pat);
        check_val("r81_shift_cycles", 32'(nsh),      32'd12);
        check_val("r81_ser_pattern",  32'(pat),      32'h810);
        check_val("r81_out_data",     32'(out_data), 32'h81);
        release_out();

        // Back-to-back with in_valid held high
        in_data = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_out = 0;
        for (int i = 0; i < 60; i++) begin
            if (in_valid && in_ready && n_acc < 2) begin
                acc_t[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid && out_ready && n_out < 2) begin
                got_w[n_out] = out_data;
                n_out++;
            end
            tick();
            if (n_acc == 1) in_data = 8'h80;
            if (n_out == 2) break;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("b2b_accepts", 32'(n_acc), 32'd2);
        check_val("b2b_outputs", 32'(n_out), 32'd2);
        if (n_out == 2) begin
            check_val("b2b_word0", 32'(got_w[0]), 32'h01);
            check_val("b2b_word1", 32'(got_w[1]), 32'h80);
        end
        if (n_acc == 2) check_val("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd14);
        tick();

        // Faulty chain (inverted last stage), then a clean transfer
        inv_en = 1'b1;
        run_word(8'h0F, nsh, pat);
        check_val("inv_out_data", 32'(out_data), 32'hF0);
        check_val("inv_err",      32'(err),      32'(exp_err));
        release_out();
        check_val("inv_err_hold", 32'(err), 32'(exp_err));
        inv_en = 1'b0;
        in_data = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("good_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check_val("good_out_data", 32'(out_data), 32'h0F);
        check_val("good_err",      32'(err),      32'd0);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
